// File: rtl/ones_counter_pkg.sv
// ones_counter_pkg
//   Shared types and parameter helpers for the sequential ones counter.
//   - state_t      : FSM state encoding (IDLE, COUNT)
//   - calc_out_w   : result width able to hold a count of 0..width
//   - calc_nchunk  : number of CHUNK-bit slices needed to cover width bits
package ones_counter_pkg;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        COUNT = 1'b1
    } state_t;

    function automatic int calc_out_w(input int width);
        return $clog2(width + 1);
    endfunction

    function automatic int calc_nchunk(input int width, input int chunk);
        return (width + chunk - 1) / chunk;
    endfunction

endpackage

// File: rtl/ones_counter_sequential_chunk_popcount.sv
// chunk_popcount
//   Purely combinational popcount of one CHUNK-bit slice.
//   Ports:
//     bits   in   CHUNK   slice to count
//     count  out  CNT_W   number of set bits in the slice
module chunk_popcount #(
    parameter int CHUNK = 8,
    parameter int CNT_W = $clog2(CHUNK + 1)
) (
    input  logic [CHUNK-1:0] bits,
    output logic [CNT_W-1:0] count
);

    always_comb begin
        count = '0;
        for (int i = 0; i < CHUNK; i++) begin
            count = count + CNT_W'(bits[i]);
        end
    end

endmodule

// File: rtl/ones_counter_sequential.sv
// ones_counter_sequential
//   Multi-cycle population counter. A WIDTH-bit word is captured on start
//   and counted CHUNK bits per clock; the total appears on out together
//   with a one-cycle done pulse.
//   Ports:
//     clk    in   1      rising-edge clock
//     rst    in   1      asynchronous, active-high reset
//     start  in   1      request, sampled only while idle
//     numb   in   WIDTH  operand, captured on the edge that accepts start
//     busy   out  1      high while a word is being counted
//     done   out  1      one-cycle pulse, out valid in the same cycle
//     out    out  OUT_W  count of the last completed word, held
//
//   Handshake: start is accepted on any rising edge where busy is low
//   (including the cycle done is high); there is no ready output and no
//   queueing, so a start while busy is simply dropped. done is a single
//   registered pulse with out already valid; out then holds until the
//   next completion or reset.
module ones_counter_sequential
    import ones_counter_pkg::*;
#(
    parameter int WIDTH = 127,
    parameter int CHUNK = 8,
    parameter int OUT_W = calc_out_w(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] numb,
    output logic             busy,
    output logic             done,
    output logic [OUT_W-1:0] out
);

    localparam int NCHUNK = calc_nchunk(WIDTH, CHUNK);
    localparam int SREG_W = NCHUNK * CHUNK;
    localparam int IDX_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam int PC_W   = $clog2(CHUNK + 1);

    state_t            state;
    logic [SREG_W-1:0] sreg;
    logic [IDX_W-1:0]  idx;
    logic [OUT_W-1:0]  acc;

    logic [PC_W-1:0]   pc;
    logic [OUT_W-1:0]  acc_next;

    chunk_popcount #(
        .CHUNK (CHUNK),
        .CNT_W (PC_W)
    ) u_chunk_popcount (
        .bits  (sreg[CHUNK-1:0]),
        .count (pc)
    );

    // The accumulator cannot overflow: its maximum is WIDTH, which OUT_W holds.
    assign acc_next = acc + OUT_W'(pc);

    // Pure state decode: no path from start to busy.
    assign busy = (state == COUNT);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            done  <= 1'b0;
            out   <= '0;
            acc   <= '0;
            idx   <= '0;
            sreg  <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        // Zero-extend into the padded register; the pad bits
                        // of the top partial chunk therefore add nothing.
                        sreg              <= '0;
                        sreg[WIDTH-1:0]   <= numb;
                        acc               <= '0;
                        idx               <= '0;
                        state             <= COUNT;
                    end
                end
                COUNT: begin
                    acc  <= acc_next;
                    sreg <= sreg >> CHUNK;
                    idx  <= idx + 1'b1;
                    if (idx == IDX_W'(NCHUNK - 1)) begin
                        out   <= acc_next;
                        done  <= 1'b1;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ones_counter_sequential.sv
// tb_ones_counter_sequential
//   Self-checking bench for ones_counter_sequential: drives directed and
//   random words, expected counts go into a queue, and a monitor compares
//   each completion against the head of that queue.
module tb_ones_counter_sequential;

    localparam int WIDTH  = 127;
    localparam int CHUNK  = 8;
    localparam int OUT_W  = 7;
    localparam int NCHUNK = 16;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic [WIDTH-1:0] numb;
    logic             busy;
    logic             done;
    logic [OUT_W-1:0] out;

    logic [OUT_W-1:0] exp_q[$];
    int               n_checks   = 0;
    int               n_pass     = 0;
    int               done_count = 0;
    int               n_sent     = 0;
    logic             prev_done  = 1'b0;

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    ones_counter_sequential #(
        .WIDTH (WIDTH),
        .CHUNK (CHUNK),
        .OUT_W (OUT_W)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .numb  (numb),
        .busy  (busy),
        .done  (done),
        .out   (out)
    );

    // ---------------- check helper ----------------
    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    endtask

    // ---------------- reference model ----------------
    function automatic logic [OUT_W-1:0] ref_count(input logic [WIDTH-1:0] w);
        return OUT_W'($countones(w));
    endfunction

    function automatic logic [WIDTH-1:0] rand_word();
        logic [127:0] r;
        r = {$urandom, $urandom, $urandom, $urandom};
        return r[WIDTH-1:0];
    endfunction

    // ---------------- driver tasks ----------------
    // Caller must be at a point where busy is low (e.g. just after a negedge).
    task automatic drive_start(input logic [WIDTH-1:0] w, input bit expect_it,
                               input logic [OUT_W-1:0] exp);
        start = 1'b1;
        numb  = w;
        if (expect_it) begin
            exp_q.push_back(exp);
            n_sent++;
        end
        @(posedge clk);
        #1;
        start = 1'b0;
        numb  = rand_word();  // later changes must not affect the result
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        @(negedge clk);
        while (busy && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("wait_idle busy", int'(busy), 0);
    endtask

    task automatic send(input logic [WIDTH-1:0] w, input logic [OUT_W-1:0] exp);
        wait_idle();
        drive_start(w, 1'b1, exp);
    endtask

    task automatic wait_done_count(input int target);
        int n;
        n = 0;
        while (done_count < target && n < 300) begin
            @(negedge clk);
            n++;
        end
        check("completions reached", done_count, target);
    endtask

    // ---------------- scoreboard monitor ----------------
    always @(negedge clk) begin
        if (done) begin
            done_count++;
            check("done pulse single cycle", int'(prev_done), 0);
            if (exp_q.size() == 0) begin
                n_checks++;
                $display("FAIL unexpected done: out=%0d with no pending word (t=%0t)", out, $time);
            end else begin
                check("out", int'(out), int'(exp_q.pop_front()));
            end
        end
        prev_done = done;
    end

    // ---------------- stimulus ----------------
    initial begin
        logic [WIDTH-1:0] w;
        int nb, lat;

        rst   = 1'b1;
        start = 1'b0;
        numb  = '0;
        repeat (2) @(negedge clk);
        check("reset busy", int'(busy), 0);
        check("reset done", int'(done), 0);
        check("reset out",  int'(out),  0);
        rst = 1'b0;

        // numb = 0: latency and busy length
        wait_idle();
        drive_start('0, 1'b1, 7'd0);
        nb  = 0;
        lat = 0;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (busy) nb++;
            if (done && lat == 0) lat = k;
        end
        check("busy cycles", nb, NCHUNK);
        check("done latency", lat - 1, NCHUNK);

        // directed words
        send({WIDTH{1'b1}}, 7'd127);
        w = '0;
        w[WIDTH-1] = 1'b1;
        send(w, 7'd1);
        send(127'b101111100011111111111111000000, 7'd20);

        // marching one, back to back
        for (int i = 0; i < WIDTH; i++) begin
            w = '0;
            w[i] = 1'b1;
            send(w, 7'd1);
        end
        wait_done_count(n_sent);

        // start while busy is ignored
        w = rand_word();
        send(w, ref_count(w));
        repeat (2) @(posedge clk);
        #1;
        start = 1'b1;
        numb  = ~w;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        start = 1'b1;
        numb  = '0;
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_done_count(n_sent);
        repeat (20) @(negedge clk);
        check("single done for ignored starts", done_count, n_sent);
        check("idle after ignored starts", int'(busy), 0);

        // back to back: zero word then all-ones in the done cycle
        send('0, 7'd0);
        nb = 0;
        @(negedge clk);
        while (busy && nb < 100) begin
            @(negedge clk);
            nb++;
        end
        check("done in first idle cycle", int'(done), 1);
        drive_start({WIDTH{1'b1}}, 1'b1, 7'd127);
        check("no idle gap busy", int'(busy), 1);
        wait_done_count(n_sent);

        // reset during COUNT cycle 7; previous out is 127
        wait_idle();
        drive_start(rand_word(), 1'b0, 7'd0);
        repeat (6) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        check("async rst busy", int'(busy), 0);
        check("async rst done", int'(done), 0);
        check("async rst out",  int'(out),  0);
        @(negedge clk);
        rst = 1'b0;

        // random words with varying density
        for (int i = 0; i < 24; i++) begin
            w = rand_word();
            case ($urandom_range(0, 2))
                1: w = w & rand_word() & rand_word();
                2: w = w | rand_word() | rand_word();
                default: ;
            endcase
            send(w, ref_count(w));
        end
        wait_done_count(n_sent);
        repeat (5) @(negedge clk);
        check("expected queue drained", exp_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
